// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue that drains one entry per cycle onto
// the register-file write port, with a youngest-first forwarding lookup.
// Optional feature: define WB_STALL_EN to add a drain_stall input that holds
// off draining while pushes continue until the queue is full.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef WB_STALL_EN
  input  logic                       drain_stall,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [DW-1:0]              wr_data,
  input  logic [AW-1:0]              chk_addr,
  output logic                       chk_hit,
  output logic [DW-1:0]              chk_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;

  logic          w_push;
  logic          w_pop;
  logic          w_stall;
  logic          w_hit;
  logic [DW-1:0] w_fwd_data;
  logic [PW-1:0] w_idx;

`ifdef WB_STALL_EN
  assign w_stall = drain_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Handshake and drain decisions; a full queue refuses pushes, so the
  // slot being written at tail never aliases the head being drained.
  assign w_push   = in_valid && (r_count < DEPTH_C);
  assign w_pop    = (r_count != '0) && !w_stall;

  assign in_ready = (r_count < DEPTH_C);
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == DEPTH_C);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign chk_hit  = w_hit;
  assign chk_data = w_fwd_data;

  // Store accepted results at the tail slot and advance the tail pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
      r_tail <= '0;
    end else if (w_push) begin
      r_mem_addr[r_tail] <= in_addr;
      r_mem_data[r_tail] <= in_data;
      r_tail             <= r_tail + PTR_ONE;
    end else begin
      r_tail <= r_tail;
    end
  end

  // Move the head entry into the output register; wr_en drops when idle
  // while address/data keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_pop) begin
      r_head    <= r_head + PTR_ONE;
      r_wr_en   <= 1'b1;
      r_wr_addr <= r_mem_addr[r_head];
      r_wr_data <= r_mem_data[r_head];
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding lookup: the output register is the oldest candidate, then
  // queue slots from head to tail-1; later matches override earlier ones so
  // the youngest matching value wins.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    if (r_wr_en && (r_wr_addr == chk_addr)) begin
      w_hit      = 1'b1;
      w_fwd_data = r_wr_data;
    end else begin
      w_hit      = 1'b0;
      w_fwd_data = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_mem_addr[w_idx] == chk_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_mem_data[w_idx];
      end else begin
        w_hit      = w_hit;
        w_fwd_data = w_fwd_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed self-checking bench for reg_wb_queue (DEPTH=4, AW=6, DW=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_wb_queue;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
`ifdef WB_STALL_EN
  logic          drain_stall;
`endif
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic [DW-1:0] chk_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  int errors;
  int checks;

  logic [DW-1:0] rf [64];

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef WB_STALL_EN
    .drain_stall(drain_stall),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .chk_data (chk_data),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: samples the write port on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) rf[wr_addr] <= wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; chk_addr = '0;
`ifdef WB_STALL_EN
    drain_stall = 1'b0;
`endif
    #12;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin errors++; $display("FAIL reset_chk: got hit=%b data=%h expected 0/0", chk_hit, chk_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_addr = 6'd5; in_data = 32'hDEADBEEF; chk_addr = 6'd5;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || wr_en !== 1'b0) begin errors++; $display("FAIL single_queued: got count=%0d wr_en=%b expected 1/0", count, wr_en); end
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_fifo: got hit=%b data=%h expected 1/deadbeef", chk_hit, chk_data); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd5 || wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got en=%b addr=%0d data=%h expected 1/5/deadbeef", wr_en, wr_addr, wr_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_out: got hit=%b data=%h expected 1/deadbeef", chk_hit, chk_data); end
    tick();
    checks++; if (wr_en !== 1'b0 || wr_addr !== 6'd5) begin errors++; $display("FAIL single_after: got en=%b addr=%0d expected 0/5", wr_en, wr_addr); end
    checks++; if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin errors++; $display("FAIL single_fwd_gone: got hit=%b data=%h expected 0/0", chk_hit, chk_data); end
    checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf: got %h expected deadbeef", rf[5]); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_addr = AW'(i); in_data = 32'h1000 + 32'(i);
      tick();
      checks++; if (in_ready !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL stream_occ_%0d: got ready=%b count=%0d expected 1/1", i, in_ready, count); end
      if (i > 1) begin
        checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(i - 1) || wr_data !== 32'h1000 + 32'(i - 1)) begin
          errors++; $display("FAIL stream_write_%0d: got en=%b addr=%0d data=%h expected 1/%0d/%h", i, wr_en, wr_addr, wr_data, i - 1, 32'h1000 + 32'(i - 1));
        end
      end else begin
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stream_first_idle: got en=%b expected 0", wr_en); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd8 || wr_data !== 32'h00001008 || count !== 3'd0) begin
      errors++; $display("FAIL stream_last: got en=%b addr=%0d data=%h count=%0d expected 1/8/00001008/0", wr_en, wr_addr, wr_data, count);
    end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stream_idle: got en=%b expected 0", wr_en); end
  endtask

  task automatic test_forward();
    chk_addr = 6'd3; in_valid = 1'b1; in_addr = 6'd3; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'd1) begin errors++; $display("FAIL fwd_first: got hit=%b data=%h expected 1/1", chk_hit, chk_data); end
    tick();
    in_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_data !== 32'd1) begin errors++; $display("FAIL fwd_out1: got en=%b data=%h expected 1/1", wr_en, wr_data); end
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'd2) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h expected 1/2", chk_hit, chk_data); end
    chk_addr = 6'd4;
    #1;
    checks++; if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin errors++; $display("FAIL fwd_miss: got hit=%b data=%h expected 0/0", chk_hit, chk_data); end
    chk_addr = 6'd3;
    tick();
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'd2 || wr_data !== 32'd2) begin errors++; $display("FAIL fwd_out2: got hit=%b data=%h wr=%h expected 1/2/2", chk_hit, chk_data, wr_data); end
    tick();
    checks++; if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin errors++; $display("FAIL fwd_done: got hit=%b data=%h expected 0/0", chk_hit, chk_data); end
    checks++; if (rf[3] !== 32'd2) begin errors++; $display("FAIL fwd_rf_last_wins: got %h expected 2", rf[3]); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = AW'(20 + i); in_data = 32'h2000 + 32'(i);
      tick();
    end
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd21) begin errors++; $display("FAIL rstmid_pre: got en=%b addr=%0d expected 1/21", wr_en, wr_addr); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || wr_addr !== 6'd0) begin
      errors++; $display("FAIL rstmid_async: got en=%b count=%0d empty=%b addr=%0d expected 0/0/1/0", wr_en, count, empty, wr_addr);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wr_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rstmid_stale_%0d: got en=%b count=%0d expected 0/0", i, wr_en, count); end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_addr = 6'd30; in_data = 32'h30;
    tick();
    in_addr = 6'd31; in_data = 32'h31;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || wr_en !== 1'b1 || wr_addr !== 6'd30) begin errors++; $display("FAIL b2b_same_edge: got count=%0d en=%b addr=%0d expected 1/1/30", count, wr_en, wr_addr); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd31 || wr_data !== 32'h31 || count !== 3'd0) begin
      errors++; $display("FAIL b2b_next: got en=%b addr=%0d data=%h count=%0d expected 1/31/31/0", wr_en, wr_addr, wr_data, count);
    end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_idle: got en=%b expected 0", wr_en); end
  endtask

`ifdef WB_STALL_EN
  task automatic test_stall();
    logic [CW-1:0] exp_cnt;
    drain_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = AW'(10 + i); in_data = 32'h100 + 32'(10 + i);
      tick();
      exp_cnt = (i < 4) ? CW'(i + 1) : 3'd4;
      checks++; if (wr_en !== 1'b0 || count !== exp_cnt) begin errors++; $display("FAIL stall_fill_%0d: got en=%b count=%0d expected 0/%0d", i, wr_en, count, exp_cnt); end
    end
    in_valid = 1'b0;
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got full=%b ready=%b expected 1/0", full, in_ready); end
    chk_addr = 6'd14;
    #1;
    checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL stall_dropped: got hit=%b expected 0", chk_hit); end
    chk_addr = 6'd13;
    #1;
    checks++; if (chk_hit !== 1'b1 || chk_data !== 32'h10D) begin errors++; $display("FAIL stall_fwd: got hit=%b data=%h expected 1/10d", chk_hit, chk_data); end
    drain_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(10 + i)) begin errors++; $display("FAIL stall_drain_%0d: got en=%b addr=%0d expected 1/%0d", i, wr_en, wr_addr, 10 + i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stall_empty: got %b expected 1", empty); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_idle: got en=%b expected 0", wr_en); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_stream();
    test_forward();
    test_reset_mid();
    test_back_to_back();
`ifdef WB_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
